pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Receiving end of the PLL control pair: drives the PLL reset and consumes its asynchronous locked flag.
//  Sequences PLL reset, waits for lock with timeout/retry, then holds lock for a qualification period
//  before releasing the downstream (40 MHz ADC) domain reset. Loss of lock re-asserts domain reset and restarts.
//  Runs on the free-running 50 MHz reference clock, so it keeps operating while the PLL is unlocked.
// PARAMETERS
//  RST_CYCLES     10     pll_rst pulse width, refclk cycles (>=1)
//  LOCK_TIMEOUT   50000  max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   consecutive synchronised-locked cycles required before release
//  MAX_RETRIES    3      failed lock attempts tolerated before FAULT (1..15)
//  CNT_W          8      width of lock_loss_cnt
// PORTS
//  refclk         in   1      free-running reference clock; all logic on rising edge
//  rst            in   1      synchronous, active-high reset
//  locked         in   1      PLL lock flag, asynchronous to refclk
//  relock_req     in   1      one-cycle pulse: force a full PLL reset sequence
//  pll_rst        out  1      reset to the PLL, active-high
//  domain_rst     out  1      active-high reset for the PLL-clocked domain (re-synchronised there)
//  ready          out  1      1 = PLL locked and qualified, domain released
//  fault          out  1      sticky: MAX_RETRIES exhausted
//  retry_cnt      out  4      failed attempts in the current sequence
//  lock_loss_cnt  out  CNT_W  RUN->lock-loss events (present only with PLL_LOCK_LOSS_CNT_EN)
// BEHAVIOUR
//  - locked passes through a 2-FF synchroniser (lock_s); all decisions use lock_s (2-cycle input latency).
//  - Reset values: state=RESET_PLL, pll_rst=1, domain_rst=1, ready=0, fault=0, retry_cnt=0,
//    lock_loss_cnt=0, all timers 0, synchroniser FFs 0.
//  - FSM, one shared down/up timer:
//    RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles -> WAIT_LOCK, timer cleared.
//    WAIT_LOCK: pll_rst=0. lock_s=1 -> STABLE. Timer reaches LOCK_TIMEOUT-1 with lock_s=0 ->
//      retry_cnt++; if new retry_cnt==MAX_RETRIES -> FAULT, else -> RESET_PLL.
//    STABLE: counts consecutive lock_s=1 cycles; lock_s=0 -> WAIT_LOCK (timer restarts, no retry charged);
//      count reaches STABLE_CYCLES -> RUN, retry_cnt cleared.
//    RUN: domain_rst=0, ready=1. lock_s=0 -> RESET_PLL, lock_loss_cnt++ (saturating at all-ones).
//    FAULT: pll_rst=1, domain_rst=1, fault=1; exits only on rst.
//  - domain_rst=1 and ready=0 in every state except RUN; both registered, change on the cycle of entering/leaving RUN.
//  - relock_req in any state but FAULT -> RESET_PLL next cycle, retry_cnt cleared, lock_loss_cnt unchanged.
//    relock_req same cycle as a lock drop in RUN: relock wins, counter still increments.
//  - Timeout and lock_s=1 on the same cycle in WAIT_LOCK: lock wins (-> STABLE).
//  - rst mid-sequence: immediate return to reset values regardless of state; FAULT cleared.
//  - Glitch on lock_s shorter than STABLE_CYCLES never releases domain_rst.
// CONFIGURATION
//  - PLL_LOCK_LOSS_CNT_EN defined: lock_loss_cnt port and saturating counter present.
//  - Undefined: port absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  - Shared package pll_sup_pkg: state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT), state width,
//    retry_cnt width constant (4).
//  - One sub-module: sync_2ff (generic 2-flop synchroniser, reusable for other async flags).
//  - Single timer width = clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1).
// TESTING (bench uses RST_CYCLES=4, LOCK_TIMEOUT=40, STABLE_CYCLES=16, MAX_RETRIES=3)
//  1 Normal: rst released, locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles;
//    ready and domain_rst toggle exactly 2+16 cycles after locked rises; retry_cnt=0.
//  2 Glitch: locked high 8 cycles, low 2, then high -> no release until 16 consecutive synced-high cycles.
//  3 Never lock: locked=0 -> 3 pll_rst pulses spaced 44 cycles; fault=1 after 3rd timeout; rst clears it.
//  4 Loss in RUN: after ready, drop locked -> domain_rst=1 and ready=0 within 3 cycles, pll_rst pulse 4 cycles,
//    lock_loss_cnt 0->1 (macro on); repeat 2^CNT_W+1 times -> counter holds 255.
//  5 relock_req in RUN and in WAIT_LOCK -> RESET_PLL next cycle, retry_cnt=0; ignored in FAULT.
//  6 rst asserted in STABLE -> all outputs at reset values next cycle; build once without the macro.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding, widths and helpers for the PLL lock supervisor
package pll_sup_pkg;
  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;
  typedef enum logic [STATE_W-1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// sync_2ff: generic two-flop synchroniser for an asynchronous single-bit flag
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) {s2_q, s1_q} <= 2'b00;
    else {s2_q, s1_q} <= {s1_q, d};
  end
  assign q = s2_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock/qualify sequencer gating the domain reset; PLL_LOCK_LOSS_CNT_EN adds lock_loss_cnt
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 10,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
`ifdef PLL_LOCK_LOSS_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               domain_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  , output logic [CNT_W-1:0] lock_loss_cnt
`endif
);
  localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic pll_rst_q, pll_rst_d, domain_rst_q, domain_rst_d, ready_q, ready_d, fault_q, fault_d;
  logic lock_s;
  sync_2ff u_sync (.clk(refclk), .rst(rst), .d(locked), .q(lock_s));
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    retry_d = retry_q;
    if (relock_req && state_q != FAULT) begin
      state_d = RESET_PLL;
      tmr_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: if (tmr_q == TW'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
        end
        WAIT_LOCK: if (lock_s) begin
          state_d = STABLE;
          tmr_d   = TW'(1);
        end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? FAULT : RESET_PLL;
          tmr_d   = '0;
        end
        STABLE: if (!lock_s) begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q >= TW'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          tmr_d   = '0;
          retry_d = '0;
        end
        RUN: begin
          tmr_d = '0;
          if (!lock_s) state_d = RESET_PLL;
        end
        FAULT: tmr_d = '0;
        default: begin
          state_d = RESET_PLL;
          tmr_d   = '0;
        end
      endcase
    end
    pll_rst_d    = state_d inside {RESET_PLL, FAULT};
    domain_rst_d = state_d != RUN;
    ready_d      = state_d == RUN;
    fault_d      = state_d == FAULT;
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= RESET_PLL;
      tmr_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end
  assign pll_rst    = pll_rst_q;
  assign domain_rst = domain_rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q, loss_d;
  always_comb loss_d = (state_q == RUN && !lock_s && loss_q != '1) ? loss_q + 1'b1 : loss_q;
  always_ff @(posedge refclk) begin
    if (rst) loss_q <= '0;
    else loss_q <= loss_d;
  end
  assign lock_loss_cnt = loss_q;
`endif
endmodule
